// File: rtl/core_network_injector_if.sv
`default_nettype none
// ============================================================================
// Module   : core_network_injector_if
// Purpose  : Core-side request/response bundle between a core and the
//            network injector.
// Ports    : req_valid/req_ready/req_write/req_addr/req_wdata (request),
//            rsp_valid/rsp_data/rsp_timeout (load response), busy.
//            master = core side, slave = injector side.
// Revision : 1.0 - initial release
// ============================================================================
interface core_network_injector_if #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 7
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_timeout;
  logic              busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_timeout, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_timeout, busy
  );
endinterface
`default_nettype wire

// File: rtl/core_network_injector.sv
`default_nettype none
// ============================================================================
// Module   : core_network_injector
// Purpose  : Queues core load/store requests, serialises them into one-cycle
//            router packets, tracks a single outstanding load and reports its
//            data (or a timeout) back to the core. Unmatched incoming packets
//            are counted in a saturating stray counter.
// Ports    : clk, reset (async, active-high)
//            core          - request/response bundle (slave side)
//            *Out          - registered packet toward the router
//            *In           - packet from the router
//            stray_count   - saturating count of unmatched incoming packets
// Revision : 1.0 - initial release
// ============================================================================
module core_network_injector #(
  parameter int DATA_W         = 6,
  parameter int NODE_ADDR_W    = 4,
  parameter int BANK_ADDR_W    = 3,
  parameter int LOCAL_ADDR     = 0,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  core_network_injector_if.slave             core,
  output logic [7:0]                         stray_count,
  output logic [NODE_ADDR_W+BANK_ADDR_W-1:0] destinationAddressOut,
  output logic [NODE_ADDR_W-1:0]             requesterAddressOut,
  output logic                               readOut,
  output logic                               writeOut,
  output logic [DATA_W-1:0]                  dataOut,
  input  logic [NODE_ADDR_W+BANK_ADDR_W-1:0] destinationAddressIn,
  input  logic [NODE_ADDR_W-1:0]             requesterAddressIn,
  input  logic                               readIn,
  input  logic                               writeIn,
  input  logic [DATA_W-1:0]                  dataIn
);

  localparam int ADDR_W  = NODE_ADDR_W + BANK_ADDR_W;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TMR_W   = $clog2(TIMEOUT_CYCLES);
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
  localparam logic [NODE_ADDR_W-1:0] LOCAL_NODE = NODE_ADDR_W'(LOCAL_ADDR);
  localparam logic [PTR_W:0]         FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [TMR_W-1:0]       TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_WAIT = 2'd2} state_t;

  // --------------------------------------------------------------------------
  // Request FIFO
  // --------------------------------------------------------------------------
  logic [ENTRY_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q;
  state_t             state_q, state_d;

  logic w_full, w_empty, w_push, w_pop;
  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;

  assign w_full  = (count_q == FULL_COUNT);
  assign w_empty = (count_q == '0);
  assign w_push  = core.req_valid && !w_full;
  assign w_pop   = (state_q == S_IDLE) && !w_empty;
  assign {head_write, head_addr, head_wdata} = fifo_mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (w_push) fifo_mem_q[wr_ptr_q] <= {core.req_write, core.req_addr, core.req_wdata};
  end

  // Pointers are log2(depth) wide, so natural overflow gives the modulo wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Packet / response state
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0]      pkt_dest_q, pkt_dest_d;
  logic [NODE_ADDR_W-1:0] pkt_req_q, pkt_req_d;
  logic                   pkt_rd_q, pkt_rd_d, pkt_wr_q, pkt_wr_d;
  logic [DATA_W-1:0]      pkt_data_q, pkt_data_d;
  logic [NODE_ADDR_W-1:0] pend_node_q, pend_node_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic                   rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
  logic [DATA_W-1:0]      rsp_data_q, rsp_data_d;
  logic [7:0]             stray_q, stray_d;

  // A reply is a write packet addressed to our node (bank ignored) that comes
  // from the node the outstanding load was sent to.
  logic w_match, w_in_pkt;
  logic unused_bank;
  assign unused_bank = ^destinationAddressIn[BANK_ADDR_W-1:0];
  assign w_in_pkt = readIn || writeIn;
  assign w_match  = (state_q == S_WAIT) && writeIn && !readIn
                 && (destinationAddressIn[ADDR_W-1 -: NODE_ADDR_W] == LOCAL_NODE)
                 && (requesterAddressIn == pend_node_q);

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    pkt_dest_d    = pkt_dest_q;
    pkt_req_d     = pkt_req_q;
    pkt_rd_d      = pkt_rd_q;
    pkt_wr_d      = pkt_wr_q;
    pkt_data_d    = pkt_data_q;
    pend_node_d   = pend_node_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    rsp_data_d    = rsp_data_q;
    stray_d       = stray_q;
    if (w_in_pkt && !w_match && (stray_q != 8'hFF)) stray_d = stray_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (!w_empty) begin
          pkt_dest_d  = head_addr;
          pkt_req_d   = LOCAL_NODE;
          pkt_wr_d    = head_write;
          pkt_rd_d    = !head_write;
          pkt_data_d  = head_write ? head_wdata : '0;
          pend_node_d = head_addr[ADDR_W-1 -: NODE_ADDR_W];
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        // The router cannot stall us, so the packet lives exactly one cycle.
        pkt_dest_d = '0;
        pkt_req_d  = '0;
        pkt_rd_d   = 1'b0;
        pkt_wr_d   = 1'b0;
        pkt_data_d = '0;
        if (pkt_wr_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
          timer_d = '0;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        // Match is tested first so a reply on the last cycle still wins.
        if (w_match) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = dataIn;
          state_d     = S_IDLE;
        end else if (timer_q == TMR_LAST) begin
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_data_d    = '0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      pkt_dest_q    <= '0;
      pkt_req_q     <= '0;
      pkt_rd_q      <= 1'b0;
      pkt_wr_q      <= 1'b0;
      pkt_data_q    <= '0;
      pend_node_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_data_q    <= '0;
      stray_q       <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      pkt_dest_q    <= pkt_dest_d;
      pkt_req_q     <= pkt_req_d;
      pkt_rd_q      <= pkt_rd_d;
      pkt_wr_q      <= pkt_wr_d;
      pkt_data_q    <= pkt_data_d;
      pend_node_q   <= pend_node_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_data_q    <= rsp_data_d;
      stray_q       <= stray_d;
    end
  end

  assign core.req_ready        = !w_full;
  assign core.rsp_valid        = rsp_valid_q;
  assign core.rsp_timeout      = rsp_timeout_q;
  assign core.rsp_data         = rsp_data_q;
  assign core.busy             = !w_empty || (state_q != S_IDLE);
  assign stray_count           = stray_q;
  assign destinationAddressOut = pkt_dest_q;
  assign requesterAddressOut   = pkt_req_q;
  assign readOut               = pkt_rd_q;
  assign writeOut              = pkt_wr_q;
  assign dataOut               = pkt_data_q;

endmodule
`default_nettype wire

// File: tb/tb_core_network_injector.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_network_injector
// Purpose  : Directed self-checking bench for core_network_injector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_network_injector;
  localparam int DATA_W = 6;
  localparam int ADDR_W = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  core_network_injector_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) cif ();

  logic [ADDR_W-1:0] dest_out, dest_in;
  logic [3:0]        req_out, req_in;
  logic              rd_out, wr_out, rd_in, wr_in;
  logic [DATA_W-1:0] data_out, data_in;
  logic [7:0]        stray;

  core_network_injector #(
    .DATA_W(DATA_W), .NODE_ADDR_W(4), .BANK_ADDR_W(3), .LOCAL_ADDR(0),
    .FIFO_DEPTH(4), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .reset(reset), .core(cif.slave), .stray_count(stray),
    .destinationAddressOut(dest_out), .requesterAddressOut(req_out),
    .readOut(rd_out), .writeOut(wr_out), .dataOut(data_out),
    .destinationAddressIn(dest_in), .requesterAddressIn(req_in),
    .readIn(rd_in), .writeIn(wr_in), .dataIn(data_in)
  );

  int checks = 0;
  int errors = 0;
  int exp_stray = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in;
    wr_in = 1'b0; rd_in = 1'b0; dest_in = '0; req_in = '0; data_in = '0;
  endtask

  task automatic drive_pkt(input logic w, input logic r, input logic [6:0] d,
                           input logic [3:0] rq, input logic [5:0] dat);
    wr_in = w; rd_in = r; dest_in = d; req_in = rq; data_in = dat;
  endtask

  // Returns #1 after the edge that accepted the request.
  task automatic push_req(input logic w, input logic [6:0] a, input logic [5:0] d);
    cif.req_valid = 1'b1; cif.req_write = w; cif.req_addr = a; cif.req_wdata = d;
    for (int i = 0; i < 40 && !cif.req_ready; i++) tick;
    checks++;
    if (cif.req_ready !== 1'b1) begin
      errors++; $display("FAIL push_ready got %0b exp 1", cif.req_ready);
    end
    tick;
    cif.req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; clear_in;
    cif.req_valid = 1'b0; cif.req_write = 1'b0; cif.req_addr = '0; cif.req_wdata = '0;
    tick; tick; tick;
    reset = 1'b0;
    tick;
    checks++; if (cif.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b exp 1", cif.req_ready); end
    checks++; if (cif.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", cif.busy); end
    checks++; if ({rd_out, wr_out, dest_out, req_out, data_out} !== '0) begin errors++; $display("FAIL rst_pkt got %h exp 0", {rd_out, wr_out, dest_out, req_out, data_out}); end
    checks++; if ({cif.rsp_valid, cif.rsp_timeout, cif.rsp_data} !== '0) begin errors++; $display("FAIL rst_rsp got %h exp 0", {cif.rsp_valid, cif.rsp_timeout, cif.rsp_data}); end
    checks++; if (stray !== 8'd0) begin errors++; $display("FAIL rst_stray got %0d exp 0", stray); end
  endtask

  task automatic test_store;
    push_req(1'b1, {4'd10, 3'd1}, 6'd42);
    checks++; if (wr_out !== 1'b0 || cif.busy !== 1'b1) begin errors++; $display("FAIL st_pre got wr=%0b busy=%0b exp wr=0 busy=1", wr_out, cif.busy); end
    tick;
    checks++; if (wr_out !== 1'b1 || rd_out !== 1'b0) begin errors++; $display("FAIL st_strobe got wr=%0b rd=%0b exp wr=1 rd=0", wr_out, rd_out); end
    checks++; if (dest_out !== {4'd10, 3'd1}) begin errors++; $display("FAIL st_dest got %h exp 51", dest_out); end
    checks++; if (req_out !== 4'd0 || data_out !== 6'd42) begin errors++; $display("FAIL st_fields got req=%0d data=%0d exp req=0 data=42", req_out, data_out); end
    tick;
    checks++; if ({rd_out, wr_out, dest_out, req_out, data_out} !== '0) begin errors++; $display("FAIL st_clear got %h exp 0", {rd_out, wr_out, dest_out, req_out, data_out}); end
    checks++; if (cif.busy !== 1'b0) begin errors++; $display("FAIL st_busy got %0b exp 0", cif.busy); end
  endtask

  task automatic test_load_match;
    int bad = 0;
    push_req(1'b0, {4'd10, 3'd1}, 6'd55);
    tick;
    checks++; if (rd_out !== 1'b1 || wr_out !== 1'b0 || dest_out !== 7'h51 || data_out !== 6'd0 || req_out !== 4'd0) begin
      errors++; $display("FAIL ld_strobe got rd=%0b wr=%0b dest=%h data=%0d exp rd=1 wr=0 dest=51 data=0", rd_out, wr_out, dest_out, data_out);
    end
    tick;
    checks++; if (rd_out !== 1'b0) begin errors++; $display("FAIL ld_clear got %0b exp 0", rd_out); end
    for (int i = 0; i < 4; i++) begin tick; if (cif.rsp_valid !== 1'b0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL ld_early_rsp got %0d exp 0", bad); end
    drive_pkt(1'b1, 1'b0, {4'd0, 3'd5}, 4'd10, 6'd42);
    tick; clear_in;
    checks++; if (cif.rsp_valid !== 1'b1 || cif.rsp_timeout !== 1'b0 || cif.rsp_data !== 6'd42) begin
      errors++; $display("FAIL ld_rsp got v=%0b to=%0b d=%0d exp v=1 to=0 d=42", cif.rsp_valid, cif.rsp_timeout, cif.rsp_data);
    end
    checks++; if (cif.busy !== 1'b0) begin errors++; $display("FAIL ld_busy got %0b exp 0", cif.busy); end
    tick;
    checks++; if (cif.rsp_valid !== 1'b0 || cif.rsp_data !== 6'd42) begin errors++; $display("FAIL ld_pulse got v=%0b d=%0d exp v=0 d=42", cif.rsp_valid, cif.rsp_data); end
    checks++; if (stray !== 8'(exp_stray)) begin errors++; $display("FAIL ld_stray got %0d exp %0d", stray, exp_stray); end
  endtask

  task automatic test_timeout;
    int bad = 0;
    push_req(1'b0, {4'd3, 3'd2}, 6'd0);
    tick; tick;   // now just after the edge that enters WAIT
    for (int i = 0; i < 63; i++) begin tick; if (cif.rsp_valid !== 1'b0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL to_early got %0d exp 0", bad); end
    tick;
    checks++; if (cif.rsp_valid !== 1'b1 || cif.rsp_timeout !== 1'b1 || cif.rsp_data !== 6'd0) begin
      errors++; $display("FAIL to_rsp got v=%0b to=%0b d=%0d exp v=1 to=1 d=0", cif.rsp_valid, cif.rsp_timeout, cif.rsp_data);
    end
    tick;
    checks++; if (cif.rsp_valid !== 1'b0 || cif.rsp_timeout !== 1'b0) begin errors++; $display("FAIL to_pulse got v=%0b to=%0b exp 0 0", cif.rsp_valid, cif.rsp_timeout); end
  endtask

  task automatic test_back_to_back;
    logic acc;
    logic exp_wr;
    int   k;
    push_req(1'b0, {4'd10, 3'd0}, 6'd0);
    for (int j = 0; j < 4; j++) push_req(1'b1, {4'(j + 1), 3'(j)}, 6'(20 + j));
    checks++; if (cif.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got %0b exp 0", cif.req_ready); end
    cif.req_valid = 1'b1; cif.req_write = 1'b1; cif.req_addr = {4'd5, 3'd4}; cif.req_wdata = 6'd24;
    drive_pkt(1'b1, 1'b0, 7'd0, 4'd10, 6'd9);
    tick; clear_in;
    checks++; if (cif.rsp_valid !== 1'b1 || cif.rsp_data !== 6'd9 || cif.rsp_timeout !== 1'b0) begin
      errors++; $display("FAIL b2b_rsp got v=%0b d=%0d to=%0b exp v=1 d=9 to=0", cif.rsp_valid, cif.rsp_data, cif.rsp_timeout);
    end
    for (int c = 1; c <= 12; c++) begin
      acc = cif.req_valid && cif.req_ready;
      tick;
      if (acc) cif.req_valid = 1'b0;
      exp_wr = (c % 2 == 1) && (c <= 9);
      k = (c - 1) / 2;
      checks++;
      if (wr_out !== exp_wr || rd_out !== 1'b0) begin
        errors++; $display("FAIL b2b_strobe c=%0d got wr=%0b rd=%0b exp wr=%0b rd=0", c, wr_out, rd_out, exp_wr);
      end else if (exp_wr && (data_out !== 6'(20 + k) || dest_out !== {4'(k + 1), 3'(k)})) begin
        errors++; $display("FAIL b2b_order c=%0d got d=%0d a=%h exp d=%0d a=%h", c, data_out, dest_out, 20 + k, {4'(k + 1), 3'(k)});
      end
    end
    checks++; if (cif.busy !== 1'b0 || cif.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_end got busy=%0b rdy=%0b exp 0 1", cif.busy, cif.req_ready); end
  endtask

  task automatic test_stray;
    drive_pkt(1'b0, 1'b1, 7'h51, 4'd3, 6'd1);
    tick; clear_in; exp_stray++;
    checks++; if (stray !== 8'(exp_stray) || cif.rsp_valid !== 1'b0) begin errors++; $display("FAIL sy_idle got s=%0d v=%0b exp s=%0d v=0", stray, cif.rsp_valid, exp_stray); end
    push_req(1'b0, {4'd10, 3'd3}, 6'd0);
    tick; tick;
    drive_pkt(1'b1, 1'b0, 7'd0, 4'd5, 6'd7);
    tick; clear_in; exp_stray++;
    checks++; if (stray !== 8'd2 || cif.rsp_valid !== 1'b0) begin errors++; $display("FAIL sy_wait got s=%0d v=%0b exp s=2 v=0", stray, cif.rsp_valid); end
    tick;
    checks++; if (cif.rsp_valid !== 1'b0) begin errors++; $display("FAIL sy_norsp got %0b exp 0", cif.rsp_valid); end
    drive_pkt(1'b1, 1'b0, {4'd0, 3'd6}, 4'd10, 6'd33);
    tick; clear_in;
    checks++; if (cif.rsp_valid !== 1'b1 || cif.rsp_data !== 6'd33 || cif.rsp_timeout !== 1'b0 || stray !== 8'd2) begin
      errors++; $display("FAIL sy_reply got v=%0b d=%0d to=%0b s=%0d exp v=1 d=33 to=0 s=2", cif.rsp_valid, cif.rsp_data, cif.rsp_timeout, stray);
    end
  endtask

  task automatic test_match_timeout;
    push_req(1'b0, {4'd10, 3'd2}, 6'd0);
    tick; tick;
    for (int i = 0; i < 63; i++) tick;
    drive_pkt(1'b1, 1'b0, 7'd0, 4'd10, 6'd17);
    tick; clear_in;
    checks++; if (cif.rsp_valid !== 1'b1 || cif.rsp_timeout !== 1'b0 || cif.rsp_data !== 6'd17) begin
      errors++; $display("FAIL mt_rsp got v=%0b to=%0b d=%0d exp v=1 to=0 d=17", cif.rsp_valid, cif.rsp_timeout, cif.rsp_data);
    end
    checks++; if (stray !== 8'(exp_stray)) begin errors++; $display("FAIL mt_stray got %0d exp %0d", stray, exp_stray); end
  endtask

  task automatic test_reset_wait;
    int bad = 0;
    push_req(1'b0, {4'd10, 3'd4}, 6'd0);
    tick; tick; tick; tick;
    reset = 1'b1;
    #1;
    exp_stray = 0;
    checks++; if (cif.busy !== 1'b0 || cif.req_ready !== 1'b1 || cif.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rw_now got busy=%0b rdy=%0b v=%0b exp 0 1 0", cif.busy, cif.req_ready, cif.rsp_valid);
    end
    checks++; if (stray !== 8'd0 || {rd_out, wr_out, dest_out, data_out} !== '0) begin errors++; $display("FAIL rw_regs got s=%0d pkt=%h exp 0 0", stray, {rd_out, wr_out, dest_out, data_out}); end
    tick;
    reset = 1'b0;
    for (int i = 0; i < 70; i++) begin tick; if (cif.rsp_valid !== 1'b0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL rw_dropped got %0d exp 0", bad); end
    drive_pkt(1'b1, 1'b0, 7'd0, 4'd10, 6'd5);
    tick; clear_in; exp_stray++;
    checks++; if (cif.rsp_valid !== 1'b0 || stray !== 8'(exp_stray)) begin errors++; $display("FAIL rw_late got v=%0b s=%0d exp v=0 s=%0d", cif.rsp_valid, stray, exp_stray); end
  endtask

  initial begin
    test_reset;
    test_store;
    test_load_match;
    test_timeout;
    test_back_to_back;
    test_stray;
    test_match_timeout;
    test_reset_wait;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
